// File: rtl/gru_htb_sched.sv
// gru_htb_sched: steps a GRU candidate-state datapath one hidden-cell row per issue, feeding each new hidden vector back as ht1.
// Latency: per step 1 + CELLNUM*(1+L) + 1 cycles (L = dp_en to dp_valid); step_valid/h_out/done land one cycle after the state that makes them.
// Backpressure: x_ready only in WAIT_X and holds there while x_valid is low; the datapath is paced by dp_valid, bounded by TIMEOUT cycles.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, h0           begin a sequence (IDLE only), initial hidden vector
//   x_valid/x_ready/x_in  one input vector per timestep
//   dp_en, dp_row, dp_xt, dp_ht1  row issue to the datapath (dp_xt/dp_ht1 stable for the whole step)
//   dp_valid, dp_result result strobe and data for the outstanding row
//   h_out, step_valid, step_idx   last completed hidden vector and its step
//   busy, done, timeout_err       status (timeout_err sticky until next accepted start)
module gru_htb_sched #(
    parameter int INPUTDIMEN = 4,
    parameter int CELLNUM    = 4,
    parameter int DATABIT    = 16,
    parameter int STEP       = 10,
    parameter int TIMEOUT    = 32,
    parameter int ROWBITS    = 2,
    parameter int STEPBITS   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CELLNUM*DATABIT-1:0]    h0,
    input  logic                          x_valid,
    output logic                          x_ready,
    input  logic [INPUTDIMEN*DATABIT-1:0] x_in,
    output logic                          dp_en,
    output logic [ROWBITS-1:0]            dp_row,
    output logic [INPUTDIMEN*DATABIT-1:0] dp_xt,
    output logic [CELLNUM*DATABIT-1:0]    dp_ht1,
    input  logic                          dp_valid,
    input  logic [DATABIT-1:0]            dp_result,
    output logic [CELLNUM*DATABIT-1:0]    h_out,
    output logic                          step_valid,
    output logic [STEPBITS-1:0]           step_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err
);

    localparam int TMOBITS = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_X,
        S_ISSUE,
        S_WAIT_RES,
        S_STEP_END,
        S_DONE
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [ROWBITS-1:0]              row;
    logic [STEPBITS-1:0]             step;
    logic [TMOBITS-1:0]              tmo;
    logic [INPUTDIMEN*DATABIT-1:0]   x_reg;
    logic [CELLNUM*DATABIT-1:0]      h_prev;
    logic [CELLNUM*DATABIT-1:0]      h_next;
    logic                            last_row;
    logic                            last_step;
    logic                            tmo_expire;

    assign last_row   = (row == ROWBITS'(CELLNUM - 1));
    assign last_step  = (step == STEPBITS'(STEP - 1));
    // tmo holds the number of silent WAIT_RES cycles already seen, so this
    // is the TIMEOUT-th silent cycle.
    assign tmo_expire = (tmo == TMOBITS'(TIMEOUT - 1));

    assign dp_row = row;
    assign dp_xt  = x_reg;
    assign dp_ht1 = h_prev;

    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        dp_en     = 1'b0;
        busy      = (state != S_IDLE);
        unique case (state)
            S_IDLE:     if (start) state_nxt = S_WAIT_X;
            S_WAIT_X: begin
                x_ready = 1'b1;
                if (x_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                dp_en     = 1'b1;
                state_nxt = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                // A result arriving on the expiry cycle still counts.
                if (dp_valid)        state_nxt = last_row ? S_STEP_END : S_ISSUE;
                else if (tmo_expire) state_nxt = S_IDLE;
            end
            S_STEP_END: state_nxt = last_step ? S_DONE : S_WAIT_X;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            row         <= '0;
            step        <= '0;
            tmo         <= '0;
            x_reg       <= '0;
            h_prev      <= '0;
            h_next      <= '0;
            h_out       <= '0;
            step_valid  <= 1'b0;
            step_idx    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            step_valid <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        h_prev      <= h0;
                        step        <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_WAIT_X: begin
                    if (x_valid) begin
                        x_reg <= x_in;
                        row   <= '0;
                    end
                end
                S_ISSUE: tmo <= '0;
                S_WAIT_RES: begin
                    if (dp_valid) begin
                        h_next[int'(row)*DATABIT +: DATABIT] <= dp_result;
                        if (!last_row) row <= row + ROWBITS'(1);
                    end else if (tmo_expire) begin
                        timeout_err <= 1'b1;
                    end else begin
                        tmo <= tmo + TMOBITS'(1);
                    end
                end
                S_STEP_END: begin
                    // h_out and step_valid move together so a consumer
                    // sampling on step_valid sees the new vector.
                    h_prev     <= h_next;
                    h_out      <= h_next;
                    step_valid <= 1'b1;
                    step_idx   <= step;
                    if (!last_step) step <= step + STEPBITS'(1);
                end
                S_DONE:  done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
